// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, code map, unit counts and the
// pattern/length encoding used by both the encoder and the future decoder.
package morse_pkg;

  localparam int unsigned CHAR_CODE_W     = 6;
  localparam int unsigned PAT_W           = 5;
  localparam int unsigned LEN_W           = 3;

  localparam int unsigned CODE_DIGIT_BASE = 26;
  localparam int unsigned CODE_SPACE      = 36;
  localparam int unsigned CODE_MAX_VALID  = 36;

  localparam int unsigned DOT_UNITS       = 1;
  localparam int unsigned DASH_UNITS      = 3;
  localparam int unsigned ELEM_GAP_UNITS  = 1;
  localparam int unsigned CHAR_GAP_UNITS  = 3;
  localparam int unsigned WORD_GAP_UNITS  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP
  } state_e;

  // pat: LSB is the first element, 1 = dash; len: element count (0 for space)
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
    logic             valid;
  } morse_sym_t;

  function automatic morse_sym_t morse_lookup(input int unsigned code);
    morse_sym_t  s;
    int unsigned d;
    s = '0;
    d = 0;
    if (code < CODE_DIGIT_BASE) begin
      s.valid = 1'b1;
      case (code)
        0:  {s.len, s.pat} = {3'd2, 5'b00010};
        1:  {s.len, s.pat} = {3'd4, 5'b00001};
        2:  {s.len, s.pat} = {3'd4, 5'b00101};
        3:  {s.len, s.pat} = {3'd3, 5'b00001};
        4:  {s.len, s.pat} = {3'd1, 5'b00000};
        5:  {s.len, s.pat} = {3'd4, 5'b00100};
        6:  {s.len, s.pat} = {3'd3, 5'b00011};
        7:  {s.len, s.pat} = {3'd4, 5'b00000};
        8:  {s.len, s.pat} = {3'd2, 5'b00000};
        9:  {s.len, s.pat} = {3'd4, 5'b01110};
        10: {s.len, s.pat} = {3'd3, 5'b00101};
        11: {s.len, s.pat} = {3'd4, 5'b00010};
        12: {s.len, s.pat} = {3'd2, 5'b00011};
        13: {s.len, s.pat} = {3'd2, 5'b00001};
        14: {s.len, s.pat} = {3'd3, 5'b00111};
        15: {s.len, s.pat} = {3'd4, 5'b00110};
        16: {s.len, s.pat} = {3'd4, 5'b01011};
        17: {s.len, s.pat} = {3'd3, 5'b00010};
        18: {s.len, s.pat} = {3'd3, 5'b00000};
        19: {s.len, s.pat} = {3'd1, 5'b00001};
        20: {s.len, s.pat} = {3'd3, 5'b00100};
        21: {s.len, s.pat} = {3'd4, 5'b01000};
        22: {s.len, s.pat} = {3'd3, 5'b00110};
        23: {s.len, s.pat} = {3'd4, 5'b01001};
        24: {s.len, s.pat} = {3'd4, 5'b01101};
        25: {s.len, s.pat} = {3'd4, 5'b00011};
        default: s = '0;
      endcase
    end else if (code < CODE_SPACE) begin
      // Digits 0-5 are dashes shifted out by dots; 6-9 are leading dashes only
      d       = code - CODE_DIGIT_BASE;
      s.valid = 1'b1;
      s.len   = LEN_W'(5);
      s.pat   = (d <= 5) ? PAT_W'(32'h1F << d) : PAT_W'((32'd1 << (d - 5)) - 32'd1);
    end else if (code <= CODE_MAX_VALID) begin
      s.valid = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// Character handshake between the mode/keypad front end and the Morse encoder.
interface morse_encoder_if #(
  parameter int unsigned CODE_W = morse_pkg::CHAR_CODE_W
);
  logic              char_valid;
  logic [CODE_W-1:0] char_code;
  logic              char_ready;

  modport master (output char_valid, output char_code, input  char_ready);
  modport slave  (input  char_valid, input  char_code, output char_ready);
endinterface

// File: rtl/morse_rom.sv
// Combinational character code -> {len, pat, valid} lookup.
module morse_rom
  import morse_pkg::*;
#(
  parameter int unsigned CODE_W = CHAR_CODE_W
) (
  input  logic [CODE_W-1:0] char_code_i,
  output morse_sym_t        sym_c_o
);

  assign sym_c_o = morse_lookup(32'(char_code_i));

endmodule

// File: rtl/morse_encoder.sv
// Encoder-mode datapath: plays accepted characters out as Morse keying on
// key_out with standard unit timing.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 20_000_000,
  parameter int unsigned CODE_W      = CHAR_CODE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  morse_encoder_if.slave        char_if,
  output logic                  key_out,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CNT_W = $clog2(WORD_GAP_UNITS * UNIT_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DOT_END  = CNT_W'(DOT_UNITS      * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_END = CNT_W'(DASH_UNITS     * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ELEM_END = CNT_W'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHAR_END = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_END = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_end_c;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             key_d, busy_d, err_d;
  logic             accept_c;
  logic             done_c;
  morse_sym_t       sym_c;

  morse_rom #(.CODE_W(CODE_W)) u_rom (
    .char_code_i (char_if.char_code),
    .sym_c_o     (sym_c)
  );

  assign char_if.char_ready = (state_q == ST_IDLE) && en;
  assign accept_c           = char_if.char_valid && char_if.char_ready;

  // Terminal count of the current state; the counter restarts on every entry
  always_comb begin
    cnt_end_c = '0;
    unique case (state_q)
      ST_MARK:     cnt_end_c = pat_q[0] ? DASH_END : DOT_END;
      ST_GAP:      cnt_end_c = ELEM_END;
      ST_CHAR_GAP: cnt_end_c = CHAR_END;
      ST_WORD_GAP: cnt_end_c = WORD_END;
      default:     cnt_end_c = '0;
    endcase
  end

  assign done_c = (cnt_q == cnt_end_c);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    pat_d   = pat_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept_c) begin
          if (!sym_c.valid) begin
            err_d = 1'b1;
          end else if (char_if.char_code == CODE_W'(CODE_SPACE)) begin
            state_d = ST_WORD_GAP;
          end else begin
            state_d = ST_MARK;
            pat_d   = sym_c.pat;
            rem_d   = sym_c.len;
          end
        end
      end
      ST_MARK: begin
        if (done_c) begin
          cnt_d   = '0;
          state_d = (rem_q == LEN_W'(1)) ? ST_CHAR_GAP : ST_GAP;
        end
      end
      ST_GAP: begin
        if (done_c) begin
          cnt_d   = '0;
          state_d = ST_MARK;
          pat_d   = pat_q >> 1;
          rem_d   = rem_q - LEN_W'(1);
        end
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (done_c) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    key_d  = (state_d == ST_MARK);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      rem_q   <= '0;
      key_out <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      key_out <= key_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: directed and random characters checked cycle by
// cycle against a waveform built from textual Morse strings.
module tb_morse_encoder;

  localparam int unsigned U = 4;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic key_out;
  logic busy;
  logic err;

  int checks   = 0;
  int failures = 0;

  bit exp_key[$];

  string MORSE [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  always #5 clk = ~clk;

  morse_encoder_if #(.CODE_W(6)) char_if ();

  morse_encoder #(.UNIT_CYCLES(U), .CODE_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .char_if (char_if),
    .key_out (key_out),
    .busy    (busy),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Per-cycle key level starting the cycle after acceptance
  function automatic void build_expected(input int code);
    string s;
    int    u;
    exp_key.delete();
    if (code == 36) begin
      repeat (7 * U) exp_key.push_back(1'b0);
    end else if (code < 36) begin
      s = MORSE[code];
      for (int i = 0; i < s.len(); i++) begin
        u = (s.getc(i) == "-") ? 3 : 1;
        repeat (u * U) exp_key.push_back(1'b1);
        if (i < s.len() - 1) repeat (U) exp_key.push_back(1'b0);
      end
      repeat (3 * U) exp_key.push_back(1'b0);
    end
  endfunction

  function automatic int rand_code();
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 36));
    return int'($urandom_range(37, 63));
  endfunction

  // Called at a negedge; returns at the negedge of the first IDLE cycle
  task automatic send(input int code, input int next_code, input bit drop_en);
    int n;
    char_if.char_valid = 1'b1;
    char_if.char_code  = 6'(code);
    n = 0;
    while (char_if.char_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("ready_timeout", 0, 1);
      char_if.char_valid = 1'b0;
      return;
    end
    build_expected(code);
    @(negedge clk);
    if (next_code >= 0) char_if.char_code = 6'(next_code);
    else char_if.char_valid = 1'b0;
    if (exp_key.size() == 0) begin
      chk("err_pulse", err, 1);
      chk("inv_key", key_out, 0);
      chk("inv_busy", busy, 0);
      chk("inv_ready", char_if.char_ready, 1);
      @(negedge clk);
      chk("err_clear", err, 0);
      return;
    end
    foreach (exp_key[i]) begin
      if (i > 0) @(negedge clk);
      if (drop_en && i == exp_key.size() / 2) en = 1'b0;
      chk($sformatf("key c%0d t%0d", code, i), key_out, exp_key[i]);
      chk($sformatf("busy c%0d t%0d", code, i), busy, 1);
      chk("err_quiet", err, 0);
      chk("ready_while_busy", char_if.char_ready, 0);
    end
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_key", key_out, 0);
    chk("end_ready", char_if.char_ready, en);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int code;
    int nxt;
    rst                = 1'b1;
    en                 = 1'b1;
    char_if.char_valid = 1'b0;
    char_if.char_code  = 6'd0;
    repeat (2) @(negedge clk);
    chk("rst_key", key_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", char_if.char_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", char_if.char_ready, 1);

    send(4, -1, 1'b0);
    send(0, -1, 1'b0);
    send(26, -1, 1'b0);
    send(36, 19, 1'b0);
    send(19, -1, 1'b0);
    send(40, -1, 1'b0);

    en                 = 1'b0;
    char_if.char_valid = 1'b1;
    char_if.char_code  = 6'd5;
    repeat (4) begin
      @(negedge clk);
      chk("en_low_ready", char_if.char_ready, 0);
      chk("en_low_busy", busy, 0);
      chk("en_low_key", key_out, 0);
    end
    char_if.char_valid = 1'b0;
    en                 = 1'b1;
    @(negedge clk);

    send(1, -1, 1'b1);
    en = 1'b1;
    @(negedge clk);

    // Reset in the middle of a dash
    char_if.char_valid = 1'b1;
    char_if.char_code  = 6'd19;
    @(negedge clk);
    char_if.char_valid = 1'b0;
    chk("pre_rst_key", key_out, 1);
    repeat (5) @(negedge clk);
    chk("mid_dash_key", key_out, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_key", key_out, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ready", char_if.char_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("after_rst_key", key_out, 0);
      chk("after_rst_busy", busy, 0);
    end
    chk("after_rst_ready", char_if.char_ready, 1);

    code = rand_code();
    for (int k = 0; k < 25; k++) begin
      nxt = (k < 24 && code <= 36 && $urandom_range(0, 1) == 1) ? rand_code() : -1;
      send(code, nxt, 1'b0);
      if (nxt < 0) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        code = rand_code();
      end else begin
        code = nxt;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
Encoder-mode datapath: converts a character code (A-Z, 0-9, word space) into a timed Morse on/off keying signal on key_out, which drives the LED and buzzer.
Sits beside the mode switch and is enabled when mode selects the encoder (mode=0).
Characters are accepted through a valid/ready handshake and played out using standard Morse unit timing.

Parameters:
UNIT_CYCLES, 20_000_000, clk cycles per Morse time unit (200 ms at 100 MHz); benches override to 4
CODE_W, 6, width of char_code

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  encoder mode enable (mode==0); when low, no new character is accepted
char_valid  in  1  character code is valid
char_code  in  6  0-25 = 'A'-'Z', 26-35 = '0'-'9', 36 = word space, 37-63 invalid
char_ready  out  1  block can accept a character this cycle
key_out  out  1  Morse keying output, 1 = tone/LED on
busy  out  1  a character is being played out
err  out  1  one-cycle pulse when an invalid code is accepted

Behaviour:
- Reset values (asynchronous): key_out=0, busy=0, err=0, char_ready=1 (IDLE); unit counter=0; all latched pattern/length registers=0.
- char_ready = (state==IDLE) && en. A character is accepted at a clock edge where char_valid && char_ready.
- On acceptance the block latches the pattern (5 bits, LSB = first element, 1 = dash) and the length (1-5) from ROM. It then goes to MARK on the next edge, and key_out rises registered, exactly 1 cycle after acceptance.
- States: IDLE, MARK, GAP, CHAR_GAP, WORD_GAP.
- MARK: key_out=1 for 1 unit (dot) or 3 units (dash).
  - Not the last element -> GAP.
  - Last element -> CHAR_GAP.
- GAP: key_out=0 for 1 unit, then MARK for the next element. The pattern shifts right and the remaining count decrements.
- CHAR_GAP: key_out=0 for 3 units, then IDLE.
- WORD_GAP (code 36): key_out=0 for 7 units, then IDLE.
- Duration of N units = exactly N*UNIT_CYCLES cycles. The unit counter clears on every state entry; no drift across elements.
- busy=1 in all states except IDLE.
- Invalid code (37-63): accepted by the handshake. err=1 for the cycle after acceptance; state stays IDLE; key_out stays 0.
- en falling mid-character: the current character finishes; only new acceptance is blocked.
- Back-to-back: if char_valid is held, the next character is accepted on the first cycle IDLE is re-entered (zero bubble beyond the CHAR_GAP).
- rst mid-operation: key_out drops to 0 immediately and state returns to IDLE; the partial character is discarded and never resumed.
- Counter width = $clog2(7*UNIT_CYCLES)+1; no wrap within a state.

Decomposition:
- Package morse_pkg holds:
  - state enum
  - code constants (CODE_SPACE=36, CODE_MAX_VALID=36, digit base 26)
  - unit counts (DOT=1, DASH=3, ELEM_GAP=1, CHAR_GAP=3, WORD_GAP=7)
  - the pattern/length encoding shared with the future decoder block
- One sub-module, morse_rom: a combinational char_code -> {len[2:0], pat[4:0], valid} lookup, reused by the decoder for reverse matching.

Test Plan:
1. Reset with UNIT_CYCLES=4 -> key_out=0, char_ready=1, busy=0, err=0; assert rst mid-dash -> key_out=0 in the same cycle, state IDLE, char_ready=1 after release.
2. Send 'E' (code 4) -> key_out rises 1 cycle after acceptance, high 4 cycles, low 12 cycles, char_ready returns 17 cycles after the accept edge.
3. Send 'A' (code 0) -> key_out high 4, low 4, high 12, low 12 (32 cycles total), busy=1 throughout.
4. Send '0' (code 26) -> five dashes of 12 high cycles separated by 4 low cycles, then 12 low; 88 cycles total.
5. Send space (36) -> key_out stays 0 for 28 cycles with busy=1; then hold char_valid with 'T' (19) -> accepted on the first IDLE cycle, key high 12 cycles.
6. Send code 40 -> err high exactly 1 cycle, key_out=0, char_ready=1 the next cycle; with en=0 and char_valid=1 -> no acceptance, char_ready=0.
